// File: rtl/alu_checker.sv
// alu_checker: exhaustive self-test sequencer for a small combinational ALU.
// It walks every (op, x, y) vector for the ops enabled in op_mask, holds each
// vector for SETTLE cycles, then compares the ALU outputs with a reference
// model on one extra cycle. It counts mismatches and captures the first one.
module alu_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       op_mask,
    output logic [2:0]       op,
    output logic [WIDTH-1:0] in_x,
    output logic [WIDTH-1:0] in_y,
    output logic             in_c,
    input  logic [WIDTH-1:0] out_s,
    input  logic             out_c,
    input  logic             zero,
    input  logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic             err_valid,
    output logic [2:0]       err_op,
    output logic [WIDTH-1:0] err_x,
    output logic [WIDTH-1:0] err_y
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        COMPARE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    // Settle counter only has to reach SETTLE-1; keep it at least one bit wide.
    localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] VAL_MAX    = '1;

    state_t          state;
    logic [CW-1:0]   settle_cnt;
    logic [7:0]      mask_q;     // op_mask frozen at start; mid-sweep edits ignored

    // Reference results for the vector currently on the ALU inputs.
    logic [WIDTH-1:0] exp_s;
    logic             exp_c;
    logic             exp_of;
    logic             exp_z;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic             mismatch;

    // Op search results: bit 3 = an enabled op was found, bits 2:0 = that op.
    logic [3:0]       first_sel;
    logic [3:0]       next_sel;
    logic [15:0]      err_count_inc;

    // Lowest enabled op whose index is >= from; found bit clear if none remain.
    function automatic logic [3:0] find_op(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b0000;
        // Scan downward so the lowest qualifying op is the one left in r.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // The carry input of the ALU under test is never exercised.
    assign in_c = 1'b0;

    // First op of a new sweep comes from the live mask, later ops from the frozen one.
    assign first_sel = find_op(op_mask, 4'd0);
    assign next_sel  = find_op(mask_q, {1'b0, op} + 4'd1);

    // Error counter saturates instead of wrapping so a huge failure stays visible.
    assign err_count_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    // Reference ALU model evaluated on the driven operands.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value held and infer a latch.
        exp_s   = '0;
        exp_c   = 1'b0;
        exp_of  = 1'b0;
        sum_add = {1'b0, in_x} + {1'b0, in_y};
        sum_sub = {1'b0, in_x} + {1'b0, ~in_y} + {{WIDTH{1'b0}}, 1'b1};
        case (op)
            3'b000: begin
                exp_s  = sum_add[WIDTH-1:0];
                exp_c  = sum_add[WIDTH];
                exp_of = (in_x[WIDTH-1] == in_y[WIDTH-1]) &&
                         (sum_add[WIDTH-1] != in_x[WIDTH-1]);
            end
            3'b001: begin
                exp_s  = sum_sub[WIDTH-1:0];
                exp_c  = sum_sub[WIDTH];
                exp_of = (in_x[WIDTH-1] != in_y[WIDTH-1]) &&
                         (sum_sub[WIDTH-1] != in_x[WIDTH-1]);
            end
            3'b010:  exp_s = ~in_x;
            3'b011:  exp_s = in_x & in_y;
            3'b100:  exp_s = in_x | in_y;
            3'b101:  exp_s = in_x ^ in_y;
            3'b110:  exp_s = WIDTH'($signed(in_x) < $signed(in_y));
            default: exp_s = WIDTH'(in_x == in_y);
        endcase
        exp_z    = (exp_s == '0);
        mismatch = (out_s != exp_s) || (out_c != exp_c) ||
                   (overflow != exp_of) || (zero != exp_z);
    end

    // Sweep sequencer: state, vector counters, error bookkeeping, status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the frozen mask, has a reset value,
            // so the block leaves reset fully defined without relying on start.
            state      <= IDLE;
            settle_cnt <= '0;
            mask_q     <= '0;
            op         <= '0;
            in_x       <= '0;
            in_y       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            err_valid  <= 1'b0;
            err_op     <= '0;
            err_x      <= '0;
            err_y      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // register values from before this edge; done defaults low (a pulse).
            done <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        mask_q     <= op_mask;
                        err_count  <= '0;
                        err_valid  <= 1'b0;
                        pass       <= 1'b0;
                        in_x       <= '0;
                        in_y       <= '0;
                        settle_cnt <= '0;
                        if (first_sel[3]) begin
                            state <= APPLY;
                            op    <= first_sel[2:0];
                            busy  <= 1'b1;
                        end else begin
                            // Empty sweep: trivially passes, reports at once.
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end
                    end
                end

                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                COMPARE: begin
                    if (mismatch) begin
                        err_count <= err_count_inc;
                        if (!err_valid) begin
                            err_valid <= 1'b1;
                            err_op    <= op;
                            err_x     <= in_x;
                            err_y     <= in_y;
                        end
                    end
                    state <= APPLY;
                    // in_y innermost, then in_x, then the next enabled op.
                    if (in_y != VAL_MAX) begin
                        in_y <= in_y + 1'b1;
                    end else begin
                        in_y <= '0;
                        if (in_x != VAL_MAX) begin
                            in_x <= in_x + 1'b1;
                        end else begin
                            in_x <= '0;
                            if (next_sel[3]) begin
                                op <= next_sel[2:0];
                            end else begin
                                // Last vector: the verdict includes this compare.
                                state <= FINISH;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (err_count == '0) && !mismatch;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 Parameter: WIDTH, default 4, ALU operand/result width.
REQ-002 Parameter: SETTLE, default 1, min 1, cycles a vector is held before the compare cycle.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request a sweep; sampled only in IDLE or FINISH.
REQ-006 Port: op_mask  input  8  bit k=1 enables ALU op k in the sweep; sampled with start.
REQ-007 Port: op, in_x, in_y, in_c  output  3/WIDTH/WIDTH/1  drive the ALU under test.
REQ-008 Port: out_s, out_c, zero, overflow  input  WIDTH/1/1/1  ALU results, combinational from op/in_*.
REQ-009 Port: busy  output  1  sweep in progress.
REQ-010 Port: done  output  1  one-cycle pulse at sweep end.
REQ-011 Port: pass  output  1  last sweep had err_count==0; valid from done until next start.
REQ-012 Port: err_count  output  16  mismatching vectors, saturating at 16'hFFFF.
REQ-013 Port: err_valid, err_op, err_x, err_y  output  1/3/WIDTH/WIDTH  capture of first failing vector.

Function
REQ-014 States SHALL be IDLE, APPLY, COMPARE, FINISH.
REQ-015 IDLE/FINISH + start=1 -> APPLY with first enabled op, in_x=0, in_y=0; clear err_count, err_valid, pass; busy=1 from next cycle.
REQ-016 IDLE/FINISH + start=1 + op_mask==0 -> FINISH directly, done=1 next cycle, pass=1, err_count=0.
REQ-017 APPLY SHALL last exactly SETTLE cycles, then COMPARE for 1 cycle; op/in_x/in_y constant across both.
REQ-018 Sweep order: in_y innermost (0..2^WIDTH-1), then in_x, then op ascending; disabled ops skipped without consuming cycles.
REQ-019 in_c SHALL be driven 0 at all times.
REQ-020 Expected results, x/y as driven, s truncated to WIDTH: 000 add s=x+y, c=carry-out, of=signed overflow; 001 sub s=x+~y+1, c=carry-out of that sum, of=signed overflow; 010 s=~x; 011 s=x&y; 100 s=x|y; 101 s=x^y; 110 s=(signed x<signed y); 111 s=(x==y); ops 010..111 c=0, of=0; all ops z=(s==0).
REQ-021 In COMPARE, any mismatch of out_s, out_c, overflow, zero SHALL count as one error (err_count+1, saturating).
REQ-022 First error of a sweep SHALL set err_valid=1 and latch op/in_x/in_y; later errors do not overwrite.
REQ-023 After COMPARE of last vector of last enabled op -> FINISH; done=1 for exactly that first FINISH cycle, busy=0, pass=(err_count==0) including final compare.
REQ-024 Cycles from start sample edge to done-high edge SHALL equal 1 + N*(SETTLE+1), N=256*popcount(op_mask) for WIDTH=4.
REQ-025 start while busy SHALL be ignored; op_mask changes mid-sweep SHALL have no effect.
REQ-026 Counter wrap of in_y/in_x SHALL not produce extra or skipped vectors.

Reset
REQ-027 rst_n low at any time, including mid-sweep, SHALL immediately force IDLE: op=0, in_x=0, in_y=0, in_c=0, busy=0, done=0, pass=0, err_count=0, err_valid=0, err_op/err_x/err_y=0.
REQ-028 After rst_n rises, no sweep starts until start is sampled high.

Verification
REQ-029 Correct ALU model, op_mask=8'hFF, SETTLE=1, start one cycle -> done after 4097 cycles, pass=1, err_count=0, err_valid=0.
REQ-030 ALU with out_c stuck 0, op_mask=8'h01 -> err_count=120, err_op=000, err_x=1, err_y=15, pass=0.
REQ-031 ALU with zero stuck 0, op_mask=8'h01 -> err_count=16, first error x=0 y=0; SETTLE=3 -> done after 1025 cycles.
REQ-032 op_mask=8'h00, start -> done next cycle, pass=1, busy never 1.
REQ-033 rst_n pulsed low mid-sweep (op=011, x=5) -> all outputs reset values same cycle; new start re-sweeps from op first-enabled, x=0, y=0.
REQ-034 start re-asserted and op_mask changed while busy -> no restart, sweep completes with original mask and cycle count.
